l2_fill_queue: RTL
==================

// Module: l2_fill_queue
// PURPOSE
//  Buffers line-fill requests from the L1 instruction cache toward the next-level cache.
//  Accepts 26-bit line addresses (addr[31:6]) on the L1 miss path.
//  Presents them in order to the next-level cache over a valid/ready handshake.
//  Suppresses duplicate in-flight line addresses, and counts issued, merged and dropped requests for the statistics module.
// PARAMETERS
//  DEPTH      8   number of queue entries (power of two, >=2)
//  PTR_BITS   3   log2(DEPTH)
//  ADDR_BITS  26  line-address width (tag+index, offset stripped)
// PORTS
//  clk         in   1            rising-edge clock, single clock domain
//  rst         in   1            synchronous, active-high reset
//  flush       in   1            synchronous clear; driven on trace RESET command (n=8)
//  fill_valid  in   1            fill_addr carries a new miss line address this cycle
//  fill_addr   in   ADDR_BITS    line address of the L1 miss
//  req_valid   out  1            head entry valid toward next-level cache
//  req_addr    out  ADDR_BITS    head entry line address
//  req_ready   in   1            next level accepts head this cycle
//  count       out  PTR_BITS+1   current occupancy, 0..DEPTH
//  full        out  1            count==DEPTH
//  empty       out  1            count==0
//  issued      out  32           requests handed to next level (req_valid&&req_ready)
//  merged      out  32           pushes suppressed as duplicates
//  dropped     out  32           pushes lost to overflow
//  overflow    out  1            sticky: set on first drop, cleared only by rst/flush
// BEHAVIOUR
//  - Reset (rst) and flush behave identically. All entries are invalidated, and rd/wr pointers go to 0.
//    count=0, empty=1, full=0, req_valid=0, req_addr=0, issued/merged/dropped=0, overflow=0.
//  - rst/flush take priority over every other input in the same cycle. A push or pop in that cycle is discarded and not counted.
//  - Storage: circular buffer, DEPTH entries, each entry a valid bit and an address.
//    Pointers are PTR_BITS wide and wrap DEPTH-1 -> 0.
//  - req_valid = !empty. req_addr = mem[rd_ptr] (0 when empty). Both are driven from registers only, with no input-to-output combinational path.
//  - Pop: req_valid && req_ready at an edge does the following:
//    rd_ptr advances, the entry valid bit clears, and issued increments.
//    req_ready while empty has no effect.
//  - Push decision on fill_valid, evaluated against the pre-edge contents:
//    a) DUP: fill_addr equals the address of any valid entry, including the head popped this same cycle.
//       No write; merged+1.
//    b) else if !full, or full with a pop this same cycle: write at wr_ptr, then wr_ptr+1.
//    c) else (full, no pop): no write; dropped+1; overflow<=1.
//  - Simultaneous push+pop: count is unchanged when the push is written. count-1 when the push merges.
//  - Latency: an entry written at edge t appears on req_valid/req_addr after edge t when the queue was empty.
//    Otherwise it follows strict FIFO order. Minimum fill-to-request latency is 1 cycle.
//  - The head is held stable (req_addr constant) while req_valid && !req_ready.
//  - Counters are 32-bit and wrap modulo 2^32 (no saturation).
//  - X/Z on fill_addr with fill_valid=0 is ignored. fill_valid=0 never changes merged/dropped.
// TESTING
//  1. rst high 1 cycle -> next cycle count=0, empty=1, req_valid=0, issued=merged=dropped=0, overflow=0.
//  2. Push 26'h0001234 with req_ready=0 -> 1 cycle later req_valid=1, req_addr=26'h0001234, count=1.
//     Raise req_ready -> issued=1, empty=1.
//  3. Push 26'h00000AA twice back-to-back with req_ready=0 -> count=1, merged=1.
//     Push 26'h00000AA in the same cycle as its pop -> merged=2, count=0.
//  4. req_ready=0; push 9 distinct addrs 0..8 -> count=8, full=1, dropped=1, overflow=1.
//     Drain with req_ready=1 -> req_addr sequence 0..7, then empty.
//  5. Full queue; push a new addr with req_ready=1 -> count stays 8, dropped unchanged.
//     The new addr emerges last after wr_ptr wraps to 0.
//  6. Queue holding 5 entries, counters nonzero; flush with fill_valid=1 and req_ready=1 -> all outputs at reset values.
//     The push is not stored and no counter increments.

Source files
------------

// File: rtl/l2_fill_queue.sv
// In-order line-fill request queue from L1 I-cache misses toward the next-level cache, with duplicate-line merging.
// Latency: a fill written at edge t is presented on req_valid/req_addr right after t when the queue was empty.
// Backpressure: the head is held while req_ready is low; pushes to a full queue are dropped unless the head pops that cycle.
module l2_fill_queue #(
   parameter int DEPTH     = 8,
   parameter int PTR_BITS  = 3,
   parameter int ADDR_BITS = 26
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 fill_valid,
   input  logic [ADDR_BITS-1:0] fill_addr,
   output logic                 req_valid,
   output logic [ADDR_BITS-1:0] req_addr,
   input  logic                 req_ready,
   output logic [PTR_BITS:0]    count,
   output logic                 full,
   output logic                 empty,
   output logic [31:0]          issued,
   output logic [31:0]          merged,
   output logic [31:0]          dropped,
   output logic                 overflow
);

   typedef struct packed {
      logic                 vld;
      logic [ADDR_BITS-1:0] addr;
   } entry_t;

   entry_t              mem [DEPTH];
   logic [PTR_BITS-1:0] rd_ptr;
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS:0]   cnt;
   logic                pop;
   logic                hit;
   logic                do_wr;
   logic                do_drop;

   // The popping head still counts as in flight, so a matching push merges into it.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i].vld && (mem[i].addr == fill_addr)) hit = 1'b1;
      end
   end

   assign empty     = (cnt == '0);
   assign full      = (cnt == (PTR_BITS+1)'(DEPTH));
   assign count     = cnt;
   assign req_valid = !empty;
   assign req_addr  = empty ? '0 : mem[rd_ptr].addr;

   assign pop     = req_valid && req_ready;
   assign do_wr   = fill_valid && !hit && (!full || pop);
   assign do_drop = fill_valid && !hit && full && !pop;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         issued   <= '0;
         merged   <= '0;
         dropped  <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) begin
            mem[rd_ptr].vld <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_BITS'(1);
            issued          <= issued + 32'd1;
         end
         // When full, wr_ptr equals rd_ptr; this later write must win over the valid clear above.
         if (do_wr) begin
            mem[wr_ptr] <= '{vld: 1'b1, addr: fill_addr};
            wr_ptr      <= wr_ptr + PTR_BITS'(1);
         end
         if (fill_valid && hit) merged <= merged + 32'd1;
         if (do_drop) begin
            dropped  <= dropped + 32'd1;
            overflow <= 1'b1;
         end
         case ({do_wr, pop})
            2'b10:   cnt <= cnt + (PTR_BITS+1)'(1);
            2'b01:   cnt <= cnt - (PTR_BITS+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule
